// File: rtl/ans_encoder.sv
// Byte-oriented rANS encoder: codes symbols against a host-loaded frequency table, emits
// renormalisation bytes and flushes the final state LSB-first. Option: ANS_ZERO_FREQ_CHECK_EN.
`ifndef SYM_WIDTH
`define SYM_WIDTH 2
`endif

module ans_encoder #(
    parameter int unsigned STATE_W   = 16,
    parameter int unsigned PROB_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`SYM_WIDTH-1:0] in,
    input  logic                  in_last,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [7:0]            out,
    output logic                  out_last,
    output logic                  out_vld,
    input  logic                  out_rdy,
    input  logic                  tab_we,
    input  logic [`SYM_WIDTH-1:0] tab_sym,
    input  logic [PROB_BITS:0]    tab_freq,
    input  logic [PROB_BITS-1:0]  tab_cum,
    output logic                  err
);

    localparam int unsigned NSYM   = 1 << `SYM_WIDTH;
    localparam int unsigned NB     = STATE_W / 8;
    localparam int unsigned SHIFT  = STATE_W - PROB_BITS;
    localparam int unsigned CNT_W  = $clog2(STATE_W);
    localparam int unsigned BYTE_W = $clog2(NB + 1);
    localparam logic [STATE_W-1:0] LOWER = STATE_W'(1) << (STATE_W - 8);
    localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(NB - 1);
    localparam logic [BYTE_W-1:0]  PENULT_BYTE = BYTE_W'(NB - 2);
    localparam logic               SINGLE_BYTE = (NB == 1);

    typedef enum logic [2:0] {StIdle, StPrep, StRenorm, StDiv, StUpdate, StFlush} state_e;

    state_e               state_q, state_d;
    logic [STATE_W-1:0]   x_q, x_d;
    logic [PROB_BITS:0]   f_q, f_d;
    logic [PROB_BITS-1:0] c_q, c_d;
    logic                 last_q, last_d;
    logic [STATE_W:0]     thr_q, thr_d;
    logic [PROB_BITS+1:0] rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BYTE_W-1:0]    byte_q, byte_d;
    logic [7:0]           out_q, out_d;
    logic                 out_vld_q, out_vld_d;
    logic                 out_last_q, out_last_d;

    logic [PROB_BITS:0]   freq_q [NSYM];
    logic [PROB_BITS-1:0] cum_q  [NSYM];

    logic [STATE_W-1:0]   x_sh, x_sum;
    logic [PROB_BITS+1:0] rem_sh, rem_sub;
    logic                 rem_ge, zero_f;

    assign in_rdy   = (state_q == StIdle) && !tab_we;
    assign out      = out_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;

    assign x_sh    = x_q >> 8;
    assign rem_sh  = {rem_q[PROB_BITS:0], x_q[STATE_W-1]};
    assign rem_ge  = rem_sh >= {1'b0, f_q};
    assign rem_sub = rem_sh - {1'b0, f_q};
    // Renorm guarantees x < f<<SHIFT, so this sum cannot overflow STATE_W bits.
    assign x_sum   = (x_q << PROB_BITS) + STATE_W'(rem_q) + STATE_W'(c_q);

`ifdef ANS_ZERO_FREQ_CHECK_EN
    logic err_q;
    logic err_set;
    assign zero_f  = (freq_q[in] == '0);
    assign err_set = in_rdy && in_vld && zero_f;
    assign err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
`else
    assign zero_f = 1'b0;
    assign err    = 1'b0;
`endif

    // Table has no reset; its contents are the host's responsibility.
    always_ff @(posedge clk) begin
        if (tab_we && state_q == StIdle) begin
            freq_q[tab_sym] <= tab_freq;
            cum_q[tab_sym]  <= tab_cum;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        f_d        = f_q;
        c_d        = c_q;
        last_d     = last_q;
        thr_d      = thr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (!tab_we && in_vld) begin
                    f_d    = freq_q[in];
                    c_d    = cum_q[in];
                    last_d = in_last;
                    if (zero_f) begin
                        if (in_last) begin
                            state_d    = StFlush;
                            out_d      = x_q[7:0];
                            out_vld_d  = 1'b1;
                            out_last_d = SINGLE_BYTE;
                            byte_d     = '0;
                        end
                    end else begin
                        state_d = StPrep;
                    end
                end
            end
            // Register the threshold so the table read does not feed the comparator directly.
            StPrep: begin
                thr_d   = (STATE_W + 1)'(f_q) << SHIFT;
                state_d = StRenorm;
            end
            StRenorm: begin
                if (out_vld_q) begin
                    if (out_rdy) begin
                        x_d = x_sh;
                        if ({1'b0, x_sh} >= thr_q) begin
                            out_d = x_sh[7:0];
                        end else begin
                            out_vld_d = 1'b0;
                            rem_d     = '0;
                            cnt_d     = '0;
                            state_d   = StDiv;
                        end
                    end
                end else if ({1'b0, x_q} >= thr_q) begin
                    out_d     = x_q[7:0];
                    out_vld_d = 1'b1;
                end else begin
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StDiv;
                end
            end
            // Restoring divide: x_q shifts out the dividend and in the quotient.
            StDiv: begin
                rem_d = rem_ge ? rem_sub : rem_sh;
                x_d   = {x_q[STATE_W-2:0], rem_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STATE_W - 1)) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                x_d = x_sum;
                if (last_q) begin
                    state_d    = StFlush;
                    out_d      = x_sum[7:0];
                    out_vld_d  = 1'b1;
                    out_last_d = SINGLE_BYTE;
                    byte_d     = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (out_rdy) begin
                    if (byte_q == LAST_BYTE) begin
                        x_d        = LOWER;
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        x_d        = x_sh;
                        out_d      = x_sh[7:0];
                        out_last_d = (byte_q == PENULT_BYTE);
                        byte_d     = byte_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            x_q        <= LOWER;
            f_q        <= '0;
            c_q        <= '0;
            last_q     <= 1'b0;
            thr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            f_q        <= f_d;
            c_q        <= c_d;
            last_q     <= last_d;
            thr_q      <= thr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

endmodule
